// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte buffer handshake between UART receiver and byte consumer
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 parity_error;
    logic                 stopbit_error;

    modport master (
        output data_out,
        output valid,
        output parity_error,
        output stopbit_error,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        input  parity_error,
        input  stopbit_error,
        output ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start validation, LSB-first data, parity, stop, one-entry buffer
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_i,
    input  logic      enable,
    uart_rx_if.master rx_out,
    output logic      overrun,
    output logic      busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 perr, perr_nx;
    logic                 armed, armed_nx;
    logic                 sync1, rx_s;
    logic                 commit, serr, bit_end;

    assign busy    = (state != IDLE);
    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        perr_nx  = perr;
        armed_nx = armed;
        commit   = 1'b0;
        serr     = 1'b0;
        case (state)
            IDLE: begin
                // armed only rises on a seen high level, so a held-low line (break) never retriggers
                if (rx_s) begin
                    armed_nx = 1'b1;
                end else if (armed && enable) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    armed_nx = 1'b0;
                end
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DATA;
                        idx_nx   = '0;
                        perr_nx  = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                    if (idx == IW'(DATA_BITS - 1)) begin
                        state_nx = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    perr_nx  = (^shreg) ^ rx_s ^ (PARITY_ODD != 0);
                    state_nx = STOP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STOP: begin
                // leaving at mid-stop leaves half a bit to catch the next start edge
                if (bit_end) begin
                    cnt_nx   = '0;
                    commit   = 1'b1;
                    serr     = ~rx_s;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            commit   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1                <= 1'b1;
            rx_s                 <= 1'b1;
            state                <= IDLE;
            cnt                  <= '0;
            idx                  <= '0;
            shreg                <= '0;
            perr                 <= 1'b0;
            armed                <= 1'b0;
            rx_out.data_out      <= '0;
            rx_out.valid         <= 1'b0;
            rx_out.parity_error  <= 1'b0;
            rx_out.stopbit_error <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            sync1   <= rx_i;
            rx_s    <= sync1;
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            shreg   <= shreg_nx;
            perr    <= perr_nx;
            armed   <= armed_nx;
            overrun <= 1'b0;
            if (commit && (!rx_out.valid || rx_out.ready)) begin
                rx_out.data_out      <= shreg;
                rx_out.parity_error  <= perr;
                rx_out.stopbit_error <= serr;
                rx_out.valid         <= 1'b1;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (rx_out.valid && rx_out.ready) begin
                rx_out.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a frame-level reference model
module tb_uart_rx_ctrl;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst, rx_i, enable, overrun, busy;
    int   checks = 0, errors = 0;
    int   cyc = 0, rise_cyc = 0, fall_cyc = 0, start_cyc = 0;
    int   ov_seen = 0, ov_exp = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;
    exp_t exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .enable(enable),
        .rx_out(bus), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: parity error when the count of ones over data+parity is odd (even parity)
    task automatic expect_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.d  = d;
        e.pe = ((($countones(d) + int'(par)) % 2) != 0);
        e.se = (stp == 1'b0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_i = 1'b1;
        end
    endtask

    // mode: 0 plain, 1 ready pulse on commit edge, 2 enable abort at bit 4, 3 rst abort at bit 4
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int post_low, input int mode);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int j = 0; j < 11 * CPB; j++) begin
            @(negedge clk);
            if (j == 0) start_cyc = cyc;
            if (mode == 1 && j == 170) bus.ready = 1'b1;
            if (mode == 1 && j == 171) bus.ready = 1'b0;
            if (mode >= 2 && j == 84) begin
                check("busy_before_abort", busy, 1);
                if (mode == 2) enable = 1'b0;
                else rst = 1'b1;
            end
            if (mode >= 2 && j == 85) begin
                check("abort_busy", busy, 0);
                if (mode == 3) begin
                    check("rst_data_out", bus.data_out, 0);
                    check("rst_valid", bus.valid, 0);
                    check("rst_errors", {bus.parity_error, bus.stopbit_error, overrun}, 0);
                end
            end
            rx_i = bits[j / CPB];
        end
        if (mode >= 2) begin
            enable = 1'b1;
            rst    = 1'b0;
        end
        repeat (post_low) begin
            @(negedge clk);
            rx_i = 1'b0;
        end
    endtask

    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (overrun) ov_seen++;
            if (bus.valid && !prev_valid) rise_cyc = cyc;
            if (!bus.valid && prev_valid) fall_cyc = cyc;
            prev_valid = bus.valid;
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got data %0h, none expected", bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", bus.data_out, e.d);
                    check("parity_error", bus.parity_error, e.pe);
                    check("stopbit_error", bus.stopbit_error, e.se);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] d;
        logic       flip, stp;
        int         ov0, seen_busy, waited;
        rst = 1'b1; rx_i = 1'b1; enable = 1'b1; bus.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.data_out, bus.valid, bus.parity_error, bus.stopbit_error, overrun, busy}, 0);
        rst = 1'b0;
        idle(5);

        expect_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        idle(4);
        check("valid_rise_latency", rise_cyc - start_cyc, 171);
        check("valid_width", fall_cyc - rise_cyc, 1);

        expect_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
        idle(6);

        seen_busy = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (busy) seen_busy = 1;
            rx_i = (j < 4) ? 1'b0 : 1'b1;
        end
        check("false_start_busy_seen", seen_busy, 1);
        check("false_start_busy_end", busy, 0);
        check("false_start_valid", bus.valid, 0);

        expect_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 400, 0);
        idle(20);
        check("break_single_commit", exp_q.size(), 0);

        bus.ready = 1'b0;
        expect_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h11, 1'b0, 1'b1, 0, 0);
        idle(5);
        ov0 = ov_seen;
        send_frame(8'h22, 1'b0, 1'b1, 0, 0);
        ov_exp++;
        idle(5);
        check("overrun_hold_data", bus.data_out, 8'h11);
        check("overrun_hold_valid", bus.valid, 1);
        check("overrun_pulses", ov_seen - ov0, 1);
        bus.ready = 1'b1;
        idle(4);

        bus.ready = 1'b0;
        expect_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h11, 1'b0, 1'b1, 0, 0);
        idle(5);
        ov0 = ov_seen;
        expect_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1);
        idle(5);
        check("drain_commit_data", bus.data_out, 8'h22);
        check("drain_commit_valid", bus.valid, 1);
        check("drain_no_overrun", ov_seen - ov0, 0);
        bus.ready = 1'b1;
        idle(4);

        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            expect_frame(d, (^d) ^ flip, stp);
            send_frame(d, (^d) ^ flip, stp, 0, 0);
            idle($urandom_range(3, 12));
        end

        send_frame(8'h55, 1'b0, 1'b1, 0, 2);
        idle(6);
        expect_frame(8'h96, 1'b0, 1'b1);
        send_frame(8'h96, 1'b0, 1'b1, 0, 0);
        idle(6);
        send_frame(8'h55, 1'b0, 1'b1, 0, 3);
        idle(6);
        expect_frame(8'h96, 1'b0, 1'b1);
        send_frame(8'h96, 1'b0, 1'b1, 0, 0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        check("overrun_total", ov_seen, ov_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
